alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_iter_unit.sv | 65 ++++++
 rtl/alu_sequencer.sv | 120 ++++++++++++
 tb/tb_alu_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state type
// for the multi-cycle ALU sequencer.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_iter_unit.sv
// Shift registers and single-step datapath for
// shift-add multiply and restoring divide.
module alu_iter_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] nxt_lo,
  output logic [WIDTH-1:0] nxt_hi
);

  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] b_q;
  logic             div_q;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   add;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // hi_q is the product high half or the
  // partial remainder; lo_q holds the
  // multiplier or the dividend/quotient.
  always_comb begin
    sum     = {1'b0, hi_q} + {1'b0, b_q};
    add     = lo_q[0] ? sum : {1'b0, hi_q};
    shifted = {hi_q, lo_q[WIDTH-1]};
    ge      = shifted >= {1'b0, b_q};
    diff    = shifted[WIDTH-1:0] - b_q;
    nxt_hi  = hi_q;
    nxt_lo  = lo_q;
    if (div_q) begin
      nxt_hi = ge ? diff : shifted[WIDTH-1:0];
      nxt_lo = {lo_q[WIDTH-2:0], ge};
    end else begin
      nxt_hi = add[WIDTH:1];
      nxt_lo = {add[0], lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      hi_q  <= '0;
      lo_q  <= a;
      b_q   <= b;
      div_q <= is_div;
    end else if (step) begin
      hi_q  <= nxt_hi;
      lo_q  <= nxt_lo;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Valid/ready ALU: single-cycle add/sub,
// iterative mul/div via alu_iter_unit.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  state_t           nxt;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last;
  logic             b_zero;
  logic             iter_op;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] it_lo;
  logic [WIDTH-1:0] it_hi;

  assign accept  = in_valid & in_ready;
  assign last    = cnt == CW'(WIDTH - 1);
  assign b_zero  = b == '0;
  assign iter_op = (op == OP_MUL) | ((op == OP_DIV) & ~b_zero);
  assign sum     = {1'b0, a} + {1'b0, b};
  assign diff    = {1'b0, a} - {1'b0, b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (accept) nxt = iter_op ? EXEC : DONE;
      EXEC: if (last) nxt = DONE;
      DONE: if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (state == EXEC) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

  // Mul/div results come from the final step
  // so they land in the same edge as DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      result_hi <= '0;
      overflow  <= 1'b0;
    end else if (accept) begin
      unique case (1'b1)
        op == OP_ADD: begin
          result    <= sum[WIDTH-1:0];
          result_hi <= '0;
          overflow  <= sum[WIDTH];
        end
        op == OP_SUB: begin
          result    <= diff[WIDTH-1:0];
          result_hi <= '0;
          overflow  <= diff[WIDTH];
        end
        (op == OP_DIV) && b_zero: begin
          result    <= '1;
          result_hi <= a;
          overflow  <= 1'b1;
        end
        default: ;
      endcase
    end else if ((state == EXEC) && last) begin
      result    <= it_lo;
      result_hi <= it_hi;
      overflow  <= 1'b0;
    end
  end

  alu_iter_unit #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .step   (state == EXEC),
    .is_div (op == OP_DIV),
    .a      (a),
    .b      (b),
    .nxt_lo (it_lo),
    .nxt_hi (it_hi)
  );

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed vector bench for alu_sequencer
// at WIDTH=4.
module tb_alu_sequencer;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] op;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] result;
  logic [3:0] result_hi;
  logic       overflow;

  int n_chk;
  int n_fail;

  typedef struct {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] res;
    logic [3:0] hi;
    logic       ovf;
    int         lat;
  } vec_t;

  vec_t vecs[12];

  alu_sequencer #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input int act,
                       input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // Accept one request, scramble the inputs,
  // then wait (bounded) for out_valid.
  task automatic issue(input logic [1:0] o,
                       input logic [3:0] x,
                       input logic [3:0] y,
                       output int lat,
                       output logic busy_ok);
    @(negedge clk);
    in_valid = 1'b1;
    op = o;
    a  = x;
    b  = y;
    check("in_ready_idle", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = ~o;
    a  = ~x;
    b  = ~y;
    lat = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    if (lat >= 40) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: got no out_valid expected within 40");
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("idle_in_ready", int'(in_ready), 1);
    check("idle_out_valid", int'(out_valid), 0);
  endtask

  initial begin
    int   lat;
    logic busy_ok;
    logic seen;

    vecs[0]  = '{2'b00, 4'd9,  4'd8, 4'd1,  4'd0,  1'b1, 1};
    vecs[1]  = '{2'b01, 4'd3,  4'd5, 4'd14, 4'd0,  1'b1, 1};
    vecs[2]  = '{2'b01, 4'd5,  4'd3, 4'd2,  4'd0,  1'b0, 1};
    vecs[3]  = '{2'b10, 4'd7,  4'd6, 4'd10, 4'd2,  1'b0, 5};
    vecs[4]  = '{2'b11, 4'd13, 4'd4, 4'd3,  4'd1,  1'b0, 5};
    vecs[5]  = '{2'b11, 4'd9,  4'd0, 4'd15, 4'd9,  1'b1, 1};
    vecs[6]  = '{2'b10, 4'd15, 4'd15, 4'd1, 4'd14, 1'b0, 5};
    vecs[7]  = '{2'b00, 4'd7,  4'd8, 4'd15, 4'd0,  1'b0, 1};
    vecs[8]  = '{2'b11, 4'd15, 4'd1, 4'd15, 4'd0,  1'b0, 5};
    vecs[9]  = '{2'b11, 4'd2,  4'd7, 4'd0,  4'd2,  1'b0, 5};
    vecs[10] = '{2'b10, 4'd0,  4'd9, 4'd0,  4'd0,  1'b0, 5};
    vecs[11] = '{2'b01, 4'd0,  4'd0, 4'd0,  4'd0,  1'b0, 1};

    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = 2'b00;
    a = 4'd0;
    b = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_result", int'(result), 0);
    check("rst_result_hi", int'(result_hi), 0);
    check("rst_overflow", int'(overflow), 0);

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, lat, busy_ok);
      check($sformatf("v%0d_result", i),
            int'(result), int'(vecs[i].res));
      check($sformatf("v%0d_result_hi", i),
            int'(result_hi), int'(vecs[i].hi));
      check($sformatf("v%0d_overflow", i),
            int'(overflow), int'(vecs[i].ovf));
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      if (vecs[i].lat > 1)
        check($sformatf("v%0d_busy", i), int'(busy_ok), 1);
      consume();
    end

    // Stall in DONE with a competing request.
    issue(2'b11, 4'd13, 4'd4, lat, busy_ok);
    @(negedge clk);
    in_valid = 1'b1;
    op = 2'b00;
    a = 4'd1;
    b = 4'd1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("stall_result", int'(result), 3);
      check("stall_result_hi", int'(result_hi), 1);
      check("stall_overflow", int'(overflow), 0);
      check("stall_out_valid", int'(out_valid), 1);
      check("stall_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("release_in_ready", int'(in_ready), 1);
    check("release_out_valid", int'(out_valid), 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("no_accept_out_valid", int'(out_valid), 0);

    // Reset in the second EXEC cycle of a mul.
    @(negedge clk);
    in_valid = 1'b1;
    op = 2'b10;
    a = 4'd7;
    b = 4'd6;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("mul_busy", int'(in_ready), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_in_ready", int'(in_ready), 1);
    check("async_out_valid", int'(out_valid), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("post_rst_no_valid", int'(seen), 0);
    check("post_rst_result", int'(result), 0);
    check("post_rst_result_hi", int'(result_hi), 0);
    check("post_rst_overflow", int'(overflow), 0);
    issue(2'b00, 4'd2, 4'd3, lat, busy_ok);
    check("after_rst_add", int'(result), 5);
    check("after_rst_lat", lat, 1);
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
